// File: rtl/pair_uart_tx_if.sv
// Pair-report handshake between the collision core and the UART transmitter.
// uart_start is a one-cycle strobe qualifying uart_tdata.
interface pair_uart_tx_if;
    logic        uart_start;
    logic [63:0] uart_tdata;

    modport master (
        output uart_start,
        output uart_tdata
    );

    modport slave (
        input uart_start,
        input uart_tdata
    );
endinterface

// File: rtl/pair_uart_tx.sv
// Buffers 64-bit pair words in a FIFO and sends each as UART 8N1 bytes, LSB first.
// Optional macro PAIR_UART_FRAME_EN wraps each word as A5 + 8 data bytes + XOR checksum.
module pair_uart_tx #(
    parameter int CLK_DIV = 868,
    parameter int FIFO_AW = 3
) (
    input  logic          eclk,
    input  logic          rst,
    pair_uart_tx_if.slave up,
    output logic          uart_txd,
    output logic          busy,
    output logic          fifo_full,
    output logic [15:0]   drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);
`ifdef PAIR_UART_FRAME_EN
    localparam logic [3:0] LAST_BYTE = 4'd9;
`else
    localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [63:0]      mem_q [DEPTH];
    logic [FIFO_AW:0] wr_q, wr_d;
    logic [FIFO_AW:0] rd_q, rd_d;
    logic [63:0]      head;
    logic             empty, full;
    logic             push, pop, drop;
    logic             bit_end, last_byte, shift_en;

    logic [1:0]       state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [63:0]      sh_q, sh_d;
    logic [7:0]       cur_byte;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic [15:0]      drop_q, drop_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                   (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign head  = mem_q[rd_q[FIFO_AW-1:0]];

    assign bit_end   = (baud_q == BAUD_MAX);
    assign last_byte = (byte_q == LAST_BYTE);

    // Pop from IDLE, or straight out of the final stop bit so words run back-to-back.
    assign pop  = !empty && ((state_q == S_IDLE) ||
                  ((state_q == S_STOP) && bit_end && last_byte));
    assign push = up.uart_start && (!full || pop);
    assign drop = up.uart_start && !push;

    assign wr_d = push ? wr_q + PTR_ONE : wr_q;
    assign rd_d = pop ? rd_q + PTR_ONE : rd_q;

`ifdef PAIR_UART_FRAME_EN
    logic [7:0] csum_q, csum_d;

    assign csum_d = pop ? (head[7:0]   ^ head[15:8]  ^ head[23:16] ^ head[31:24] ^
                           head[39:32] ^ head[47:40] ^ head[55:48] ^ head[63:56])
                        : csum_q;
    assign shift_en = (byte_q != 4'd0);

    // Select the sync byte, a data byte or the checksum for the current slot.
    always_comb begin
        cur_byte = sh_q[7:0];
        if (byte_q == 4'd0) begin
            cur_byte = 8'hA5;
        end else if (byte_q == LAST_BYTE) begin
            cur_byte = csum_q;
        end
    end

    // Checksum of the word currently being framed.
    always_ff @(posedge eclk) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign shift_en = 1'b1;
    assign cur_byte = sh_q[7:0];
`endif

    // FIFO storage; pointers alone define validity, so no reset is needed.
    always_ff @(posedge eclk) begin
        if (push) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= up.uart_tdata;
        end
    end

    // Transmit FSM next-state, baud/bit/byte counters and shift register.
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        unique case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                if (pop) begin
                    state_d = S_START;
                    byte_d  = 4'd0;
                    sh_d    = head;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!last_byte) begin
                        state_d = S_START;
                        byte_d  = byte_q + 4'd1;
                        if (shift_en) begin
                            sh_d = {8'h00, sh_q[63:8]};
                        end
                    end else if (pop) begin
                        state_d = S_START;
                        byte_d  = 4'd0;
                        sh_d    = head;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered line level and status, one cycle behind the FSM state.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            S_IDLE:  txd_d = 1'b1;
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = cur_byte[bit_q];
            S_STOP:  txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || !empty;
        drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // State update with synchronous reset aborting any frame in flight.
    always_ff @(posedge eclk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            byte_q  <= 4'd0;
            sh_q    <= 64'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            drop_q  <= 16'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign uart_txd  = txd_q;
    assign busy      = busy_q;
    assign fifo_full = full;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_pair_uart_tx.sv
// Bench for pair_uart_tx: serial decoder feeding a byte scoreboard, plus timing
// checks for latency, back-to-back words, full+pop, mid-frame reset and saturation.
`timescale 1ns/1ps
module tb_pair_uart_tx;
    localparam int DIV_A = 4;
`ifdef PAIR_UART_FRAME_EN
    localparam int NB = 10;
`else
    localparam int NB = 8;
`endif
    localparam int WT = NB * 10 * DIV_A;

    typedef struct {
        logic [63:0] w;
        logic [7:0]  b [10];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txd_a, busy_a, full_a;
    logic        txd_b, busy_b, full_b;
    logic [15:0] drop_a, drop_b;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [7:0]  sb [$];
    bit          rx_en = 1'b1;
    bit          gap_chk = 1'b0;
    bit          have_prev = 1'b0;
    int          last_t0 = 0;
    vec_t        tbl [3];

    pair_uart_tx_if ifa ();
    pair_uart_tx_if ifb ();

    pair_uart_tx #(.CLK_DIV(DIV_A), .FIFO_AW(3)) dut_a (
        .eclk      (clk),
        .rst       (rst),
        .up        (ifa),
        .uart_txd  (txd_a),
        .busy      (busy_a),
        .fifo_full (full_a),
        .drop_cnt  (drop_a)
    );

    pair_uart_tx #(.CLK_DIV(65535), .FIFO_AW(3)) dut_b (
        .eclk      (clk),
        .rst       (rst),
        .up        (ifb),
        .uart_txd  (txd_b),
        .busy      (busy_b),
        .fifo_full (full_b),
        .drop_cnt  (drop_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        logic [7:0] x;
        x = 8'h00;
`ifdef PAIR_UART_FRAME_EN
        sb.push_back(8'hA5);
`endif
        for (int i = 0; i < 8; i++) begin
            sb.push_back(w[8*i +: 8]);
            x ^= w[8*i +: 8];
        end
`ifdef PAIR_UART_FRAME_EN
        sb.push_back(x);
`endif
    endtask

    task automatic strobe_a(input logic [63:0] w);
        ifa.uart_start = 1'b1;
        ifa.uart_tdata = w;
        @(posedge clk);
        #1;
        ifa.uart_start = 1'b0;
    endtask

    task automatic wait_drain(input int lim, input string nm);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy_a) && k < lim) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_vec++;
        if (sb.size() != 0 || busy_a) begin
            n_miss++;
            $display("FAIL %s: drain timeout, %0d bytes pending, busy %0b",
                     nm, sb.size(), busy_a);
        end
    endtask

    // Serial decoder on dut_a: samples each bit cell in its middle.
    initial begin : rx
        logic [7:0] b;
        logic [7:0] e;
        logic       sbit;
        logic       pbit;
        int         t0;
        forever begin
            @(negedge clk);
            if (rx_en && txd_a === 1'b0) begin
                t0 = cyc;
                repeat (DIV_A / 2) @(negedge clk);
                sbit = txd_a;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV_A) @(negedge clk);
                    b[k] = txd_a;
                end
                repeat (DIV_A) @(negedge clk);
                pbit = txd_a;
                chk("start_bit", 64'(sbit), 64'd0);
                chk("stop_bit", 64'(pbit), 64'd1);
                if (gap_chk && have_prev) begin
                    chk("gap", 64'(t0 - last_t0), 64'(10 * DIV_A));
                end
                last_t0 = t0;
                have_prev = 1'b1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rx_extra: got byte %02h, want none", b);
                end else begin
                    e = sb.pop_front();
                    chk("rx_byte", 64'(b), 64'(e));
                end
                repeat (DIV_A / 2 - 1) @(negedge clk);
            end
        end
    end

    initial begin : main
        int lows;
        ifa.uart_start = 1'b0;
        ifa.uart_tdata = 64'd0;
        ifb.uart_start = 1'b0;
        ifb.uart_tdata = 64'd0;

`ifdef PAIR_UART_FRAME_EN
        tbl[0] = '{64'h0012_3456_0000_0ABC,
                   '{8'hA5, 8'hBC, 8'h0A, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00, 8'hC6}};
        tbl[1] = '{64'h0102_0304_0506_0708,
                   '{8'hA5, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08}};
        tbl[2] = '{64'h8000_0000_0000_0001,
                   '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h81}};
`else
        tbl[0] = '{64'h0012_3456_0000_0ABC,
                   '{8'hBC, 8'h0A, 8'h00, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00}};
        tbl[1] = '{64'h0102_0304_0506_0708,
                   '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00}};
        tbl[2] = '{64'h8000_0000_0000_0001,
                   '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00}};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 64'(txd_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_full", 64'(full_a), 64'd0);
        chk("rst_drop", 64'(drop_a), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < NB; j++) sb.push_back(tbl[i].b[j]);
            strobe_a(tbl[i].w);
            @(posedge clk);
            #1;
            chk("lat_hi", 64'(txd_a), 64'd1);
            chk("busy_on", 64'(busy_a), 64'd1);
            @(posedge clk);
            #1;
            chk("lat_lo", 64'(txd_a), 64'd0);
            repeat (WT - 1) @(posedge clk);
            #1;
            chk("busy_hold", 64'(busy_a), 64'd1);
            @(posedge clk);
            #1;
            chk("busy_off", 64'(busy_a), 64'd0);
            chk("idle_txd", 64'(txd_a), 64'd1);
            wait_drain(100, "single");
            chk("drop_zero", 64'(drop_a), 64'd0);
        end

        have_prev = 1'b0;
        gap_chk = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) push_word(64'(k));
            strobe_a(64'(k));
        end
        chk("burst_full", 64'(full_a), 64'd1);
        chk("burst_drop", 64'(drop_a), 64'd1);
        repeat (WT - 9) @(posedge clk);
        #1;
        push_word(64'hFEED_0000_CAFE_0010);
        strobe_a(64'hFEED_0000_CAFE_0010);
        chk("pop_full", 64'(full_a), 64'd1);
        chk("pop_drop", 64'(drop_a), 64'd1);
        wait_drain(11 * WT, "burst");
        gap_chk = 1'b0;

        rx_en = 1'b0;
        strobe_a(64'h1111_2222_3333_4444);
        strobe_a(64'h5555_6666_7777_8888);
        strobe_a(64'h9999_AAAA_BBBB_CCCC);
        repeat (96) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_txd", 64'(txd_a), 64'd1);
        chk("mrst_busy", 64'(busy_a), 64'd0);
        chk("mrst_full", 64'(full_a), 64'd0);
        chk("mrst_drop", 64'(drop_a), 64'd0);
        lows = 0;
        repeat (2 * WT) begin
            @(posedge clk);
            #1;
            if (txd_a !== 1'b1) lows++;
        end
        chk("no_restart", 64'(lows), 64'd0);
        chk("post_busy", 64'(busy_a), 64'd0);
        rx_en = 1'b1;

        ifb.uart_start = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            ifb.uart_tdata = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (i == 1000) chk("sat_991", 64'(drop_b), 64'd991);
            if (i == 65543) chk("sat_fffe", 64'(drop_b), 64'hFFFE);
            if (i == 65544) chk("sat_ffff", 64'(drop_b), 64'hFFFF);
        end
        ifb.uart_start = 1'b0;
        chk("sat_hold", 64'(drop_b), 64'hFFFF);
        chk("sat_full", 64'(full_b), 64'd1);
        chk("sat_busy", 64'(busy_b), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
